ex_mem_wb_pipeline_regs: RTL and testbench
==========================================

Name: ex_mem_wb_pipeline_regs

Overview:
Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core. It captures EX-stage results, presents them to data memory, selects the write-back value, and drives the destination-register and regwrite signals that the forwarding unit and the register file consume. It supports memory-wait stalls, branch/exception flushes, x0 write suppression and a retired-instruction counter.

Parameters:
XLEN, 32, datapath width.
REG_ADDR_W, 5, register address width.
CNT_W, 32, retired-instruction counter width.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
MEM_STALL  in  1  data memory not ready: freeze EX/MEM and insert a bubble into MEM/WB.
FLUSH_EX_MEM  in  1  load a bubble into EX/MEM instead of the EX inputs.
EX_VALID  in  1  the EX stage holds a real instruction.
EX_ALU_RESULT  in  XLEN  ALU result or effective address.
EX_RS2_DATA  in  XLEN  store data, already forwarded.
EX_RD  in  REG_ADDR_W  destination register.
EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG  in  1 each  control bits.
MEM_READ_DATA  in  XLEN  combinational load data from data memory.
VALID_EX_MEM  out  1  EX/MEM holds a real instruction.
ARD_EX_MEM  out  REG_ADDR_W  EX/MEM destination register.
REGWRITE_EX_MEM  out  1  qualified regwrite for EX/MEM.
ALU_RESULT_EX_MEM  out  XLEN  memory address and forwarding value.
RS2_DATA_EX_MEM  out  XLEN  store data.
MEMREAD_EX_MEM, MEMWRITE_EX_MEM  out  1 each  memory strobes.
VALID_MEM_WB  out  1  MEM/WB holds a real instruction.
ARD_MEM_WB  out  REG_ADDR_W  MEM/WB destination register.
REGWRITE_MEM_WB  out  1  qualified regwrite for MEM/WB.
WB_DATA_MEM_WB  out  XLEN  write-back and forwarding value.
RETIRED_COUNT  out  CNT_W  count of valid instructions that have left MEM/WB.

Behaviour:
- Reset (RST_N=0, asynchronous): every register and output is 0. The counter is also 0. Nothing is written to memory while in reset or in the first cycle after reset.
- Qualification: the stored regwrite bit is EX_REGWRITE & EX_VALID & (EX_RD!=0), so x0 is never reported as a writer. MEMREAD and MEMWRITE are stored ANDed with EX_VALID.
- EX/MEM update on each clock edge, in priority order:
  1. MEM_STALL=1: hold all EX/MEM fields.
  2. FLUSH_EX_MEM=1: load a bubble (valid, regwrite, memread and memwrite all 0; data fields keep their old values).
  3. Otherwise: capture the EX inputs.
- Latency: an EX input appears on the EX/MEM outputs 1 cycle later and on the MEM/WB outputs 2 cycles later, when there are no stalls.
- MEM/WB update on each clock edge:
  - MEM_STALL=1: load a bubble (valid=0, regwrite=0; ARD and WB_DATA hold their old values).
  - Otherwise: capture VALID, ARD and REGWRITE from EX/MEM. WB_DATA = MEMTOREG_EX_MEM ? MEM_READ_DATA : ALU_RESULT_EX_MEM.
- MEMTOREG_EX_MEM is an internal register only.
- Memory strobes come straight from the registers. During a stall they stay asserted, so the memory sees a stable request.
- MEM_STALL together with FLUSH_EX_MEM: the stall wins. The instruction held in EX has not been accepted, so the flush has no effect. Upstream must keep FLUSH asserted or re-present the flushed instruction once the stall drops.
- A flush never affects MEM/WB. An instruction already in EX/MEM always completes.
- RETIRED_COUNT increments by 1 on each edge where VALID_MEM_WB=1. It wraps from all-ones to 0 with no flag.
- Reset asserted mid-stall clears everything immediately. After release the block accepts EX inputs on the first edge.

Decomposition:
- Shared package core_pkg:
  - XLEN and REG_ADDR_W constants.
  - Typedef ex_mem_t: valid, rd, regwrite, memread, memwrite, memtoreg, alu_result, rs2_data.
  - Typedef mem_wb_t: valid, rd, regwrite, wb_data.
  - Bubble constants EX_MEM_BUBBLE and MEM_WB_BUBBLE.
- One natural sub-module, pipe_reg_hold_flush: a generic struct register with hold/flush inputs and a bubble value. It is instantiated twice. The counter stays in the top level.

Test Plan:
- Reset then stream. Reset, then EX_VALID=1, EX_RD=3, EX_REGWRITE=1, ALU=0x0000_0010. Required: ARD_EX_MEM=3 and REGWRITE_EX_MEM=1 after 1 cycle; ARD_MEM_WB=3 and WB_DATA=0x10 after 2 cycles; RETIRED_COUNT=1.
- x0 suppression. EX_RD=0, EX_REGWRITE=1. Required: REGWRITE_EX_MEM=0 and REGWRITE_MEM_WB=0; VALID_MEM_WB=1 and the counter increments.
- Load with stall. Load to rd=5 with MEMREAD=1, then MEM_STALL=1 for 2 cycles with MEM_READ_DATA=0xDEAD_BEEF on release. Required: EX/MEM held with MEMREAD_EX_MEM=1 during the stall; VALID_MEM_WB=0 for 2 cycles; then ARD_MEM_WB=5 and WB_DATA=0xDEADBEEF.
- Flush. Present rd=7 with FLUSH_EX_MEM=1. Required: VALID_EX_MEM=0, REGWRITE_EX_MEM=0 and MEMWRITE_EX_MEM=0; the previous EX/MEM instruction still reaches MEM/WB.
- Stall plus flush. Assert both for 1 cycle. Required: EX/MEM unchanged; MEM/WB gets a bubble.
- Async reset mid-stall. Drop RST_N while MEM_STALL=1, between clock edges. Required: all outputs 0 immediately, RETIRED_COUNT=0; the counter wraps correctly when CNT_W=4 after 16 retirements.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline types for the RV32I core: EX/MEM and MEM/WB register layouts
// plus their bubble and flush-retention constants.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       rs2_data;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic [XLEN-1:0]       wb_data;
  } mem_wb_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  // Fields set to ones survive a bubble; control bits are cleared.
  localparam ex_mem_t EX_MEM_KEEP = '{
    valid:      1'b0,
    rd:         '1,
    regwrite:   1'b0,
    memread:    1'b0,
    memwrite:   1'b0,
    memtoreg:   1'b1,
    alu_result: '1,
    rs2_data:   '1
  };

  localparam mem_wb_t MEM_WB_KEEP = '{
    valid:    1'b0,
    rd:       '1,
    regwrite: 1'b0,
    wb_data:  '1
  };

endpackage

// File: rtl/pipe_reg_hold_flush.sv
// Generic pipeline register: hold has priority over flush; a flush clears the
// bits outside KEEP to the BUBBLE value and leaves the KEEP bits untouched.
module pipe_reg_hold_flush #(
  parameter type T      = logic,
  parameter T    BUBBLE = T'(0),
  parameter T    KEEP   = T'(0)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic flush,
  input  T     d,
  output T     q
);

  T q_q;
  T q_d;

  always_comb begin
    q_d = q_q;
    if (!hold) begin
      if (flush) q_d = T'((q_q & KEEP) | (BUBBLE & ~KEEP));
      else       q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= T'(0);
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ex_mem_wb_pipeline_regs.sv
// EX/MEM and MEM/WB pipeline registers with memory-wait stall, EX/MEM flush,
// x0 regwrite suppression and a retired-instruction counter.
module ex_mem_wb_pipeline_regs
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = core_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  MEM_STALL,
  input  logic                  FLUSH_EX_MEM,
  input  logic                  EX_VALID,
  input  logic [XLEN-1:0]       EX_ALU_RESULT,
  input  logic [XLEN-1:0]       EX_RS2_DATA,
  input  logic [REG_ADDR_W-1:0] EX_RD,
  input  logic                  EX_REGWRITE,
  input  logic                  EX_MEMREAD,
  input  logic                  EX_MEMWRITE,
  input  logic                  EX_MEMTOREG,
  input  logic [XLEN-1:0]       MEM_READ_DATA,
  output logic                  VALID_EX_MEM,
  output logic [REG_ADDR_W-1:0] ARD_EX_MEM,
  output logic                  REGWRITE_EX_MEM,
  output logic [XLEN-1:0]       ALU_RESULT_EX_MEM,
  output logic [XLEN-1:0]       RS2_DATA_EX_MEM,
  output logic                  MEMREAD_EX_MEM,
  output logic                  MEMWRITE_EX_MEM,
  output logic                  VALID_MEM_WB,
  output logic [REG_ADDR_W-1:0] ARD_MEM_WB,
  output logic                  REGWRITE_MEM_WB,
  output logic [XLEN-1:0]       WB_DATA_MEM_WB,
  output logic [CNT_W-1:0]      RETIRED_COUNT
);

  ex_mem_t          ex_mem_d;
  ex_mem_t          ex_mem_q;
  mem_wb_t          mem_wb_d;
  mem_wb_t          mem_wb_q;
  logic [CNT_W-1:0] retired_d;
  logic [CNT_W-1:0] retired_q;

  always_comb begin
    ex_mem_d            = EX_MEM_BUBBLE;
    ex_mem_d.valid      = EX_VALID;
    ex_mem_d.rd         = EX_RD;
    ex_mem_d.regwrite   = EX_REGWRITE & EX_VALID & (EX_RD != '0);
    ex_mem_d.memread    = EX_MEMREAD & EX_VALID;
    ex_mem_d.memwrite   = EX_MEMWRITE & EX_VALID;
    ex_mem_d.memtoreg   = EX_MEMTOREG;
    ex_mem_d.alu_result = EX_ALU_RESULT;
    ex_mem_d.rs2_data   = EX_RS2_DATA;
  end

  // A stall freezes EX/MEM and drops a bubble into MEM/WB, so the stall wins
  // over a concurrent flush and the held instruction completes afterwards.
  pipe_reg_hold_flush #(
    .T      (ex_mem_t),
    .BUBBLE (EX_MEM_BUBBLE),
    .KEEP   (EX_MEM_KEEP)
  ) u_ex_mem (
    .clk   (CLK),
    .rst_n (RST_N),
    .hold  (MEM_STALL),
    .flush (FLUSH_EX_MEM),
    .d     (ex_mem_d),
    .q     (ex_mem_q)
  );

  always_comb begin
    mem_wb_d          = MEM_WB_BUBBLE;
    mem_wb_d.valid    = ex_mem_q.valid;
    mem_wb_d.rd       = ex_mem_q.rd;
    mem_wb_d.regwrite = ex_mem_q.regwrite;
    mem_wb_d.wb_data  = ex_mem_q.memtoreg ? MEM_READ_DATA : ex_mem_q.alu_result;
  end

  pipe_reg_hold_flush #(
    .T      (mem_wb_t),
    .BUBBLE (MEM_WB_BUBBLE),
    .KEEP   (MEM_WB_KEEP)
  ) u_mem_wb (
    .clk   (CLK),
    .rst_n (RST_N),
    .hold  (1'b0),
    .flush (MEM_STALL),
    .d     (mem_wb_d),
    .q     (mem_wb_q)
  );

  always_comb begin
    retired_d = retired_q;
    if (mem_wb_q.valid) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign VALID_EX_MEM      = ex_mem_q.valid;
  assign ARD_EX_MEM        = ex_mem_q.rd;
  assign REGWRITE_EX_MEM   = ex_mem_q.regwrite;
  assign ALU_RESULT_EX_MEM = ex_mem_q.alu_result;
  assign RS2_DATA_EX_MEM   = ex_mem_q.rs2_data;
  assign MEMREAD_EX_MEM    = ex_mem_q.memread;
  assign MEMWRITE_EX_MEM   = ex_mem_q.memwrite;
  assign VALID_MEM_WB      = mem_wb_q.valid;
  assign ARD_MEM_WB        = mem_wb_q.rd;
  assign REGWRITE_MEM_WB   = mem_wb_q.regwrite;
  assign WB_DATA_MEM_WB    = mem_wb_q.wb_data;
  assign RETIRED_COUNT     = retired_q;

endmodule

// File: tb/tb_ex_mem_wb_pipeline_regs.sv
// Scoreboard bench: stimulus pushes expected EX/MEM state and in-order
// retirements; a negedge monitor pops and compares.
module tb_ex_mem_wb_pipeline_regs;

  logic        CLK;
  logic        RST_N;
  logic        MEM_STALL;
  logic        FLUSH_EX_MEM;
  logic        EX_VALID;
  logic [31:0] EX_ALU_RESULT;
  logic [31:0] EX_RS2_DATA;
  logic [4:0]  EX_RD;
  logic        EX_REGWRITE;
  logic        EX_MEMREAD;
  logic        EX_MEMWRITE;
  logic        EX_MEMTOREG;
  logic [31:0] MEM_READ_DATA;
  logic        VALID_EX_MEM;
  logic [4:0]  ARD_EX_MEM;
  logic        REGWRITE_EX_MEM;
  logic [31:0] ALU_RESULT_EX_MEM;
  logic [31:0] RS2_DATA_EX_MEM;
  logic        MEMREAD_EX_MEM;
  logic        MEMWRITE_EX_MEM;
  logic        VALID_MEM_WB;
  logic [4:0]  ARD_MEM_WB;
  logic        REGWRITE_MEM_WB;
  logic [31:0] WB_DATA_MEM_WB;
  logic [3:0]  RETIRED_COUNT;

  ex_mem_wb_pipeline_regs #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .MEM_STALL(MEM_STALL), .FLUSH_EX_MEM(FLUSH_EX_MEM),
    .EX_VALID(EX_VALID), .EX_ALU_RESULT(EX_ALU_RESULT), .EX_RS2_DATA(EX_RS2_DATA),
    .EX_RD(EX_RD), .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD),
    .EX_MEMWRITE(EX_MEMWRITE), .EX_MEMTOREG(EX_MEMTOREG), .MEM_READ_DATA(MEM_READ_DATA),
    .VALID_EX_MEM(VALID_EX_MEM), .ARD_EX_MEM(ARD_EX_MEM), .REGWRITE_EX_MEM(REGWRITE_EX_MEM),
    .ALU_RESULT_EX_MEM(ALU_RESULT_EX_MEM), .RS2_DATA_EX_MEM(RS2_DATA_EX_MEM),
    .MEMREAD_EX_MEM(MEMREAD_EX_MEM), .MEMWRITE_EX_MEM(MEMWRITE_EX_MEM),
    .VALID_MEM_WB(VALID_MEM_WB), .ARD_MEM_WB(ARD_MEM_WB), .REGWRITE_MEM_WB(REGWRITE_MEM_WB),
    .WB_DATA_MEM_WB(WB_DATA_MEM_WB), .RETIRED_COUNT(RETIRED_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Data memory: load data is a fixed function of the address, garbage while busy.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign MEM_READ_DATA = MEM_STALL ? 32'hBAD0_BAD0 : mem_model(ALU_RESULT_EX_MEM);

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        wbv;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wb;
  } ret_t;

  exp_t exp_q[$];
  ret_t ret_q[$];

  int unsigned checks;
  int unsigned errors;

  // Architectural view of what EX/MEM should currently hold.
  logic        m_v, m_rw, m_mr, m_mw;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rs2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    exp_t        e;
    ret_t        r;
    logic [3:0]  mon_ret;
    mon_ret = '0;
    forever begin
      @(negedge CLK or negedge RST_N);
      if (!RST_N) begin
        exp_q.delete();
        ret_q.delete();
        mon_ret = '0;
        #1;
        chk("rst_valid_ex_mem", 32'(VALID_EX_MEM), 32'd0);
        chk("rst_ard_ex_mem", 32'(ARD_EX_MEM), 32'd0);
        chk("rst_regwrite_ex_mem", 32'(REGWRITE_EX_MEM), 32'd0);
        chk("rst_alu_ex_mem", ALU_RESULT_EX_MEM, 32'd0);
        chk("rst_rs2_ex_mem", RS2_DATA_EX_MEM, 32'd0);
        chk("rst_memread_ex_mem", 32'(MEMREAD_EX_MEM), 32'd0);
        chk("rst_memwrite_ex_mem", 32'(MEMWRITE_EX_MEM), 32'd0);
        chk("rst_valid_mem_wb", 32'(VALID_MEM_WB), 32'd0);
        chk("rst_ard_mem_wb", 32'(ARD_MEM_WB), 32'd0);
        chk("rst_regwrite_mem_wb", 32'(REGWRITE_MEM_WB), 32'd0);
        chk("rst_wb_data", WB_DATA_MEM_WB, 32'd0);
        chk("rst_retired_count", 32'(RETIRED_COUNT), 32'd0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_ex_mem", 32'(VALID_EX_MEM), 32'(e.v));
        chk("ard_ex_mem", 32'(ARD_EX_MEM), 32'(e.rd));
        chk("regwrite_ex_mem", 32'(REGWRITE_EX_MEM), 32'(e.rw));
        chk("memread_ex_mem", 32'(MEMREAD_EX_MEM), 32'(e.mr));
        chk("memwrite_ex_mem", 32'(MEMWRITE_EX_MEM), 32'(e.mw));
        chk("alu_ex_mem", ALU_RESULT_EX_MEM, e.alu);
        chk("rs2_ex_mem", RS2_DATA_EX_MEM, e.rs2);
        chk("valid_mem_wb", 32'(VALID_MEM_WB), 32'(e.wbv));
        chk("retired_count", 32'(RETIRED_COUNT), 32'(mon_ret));
        if (e.wbv) begin
          mon_ret = mon_ret + 4'd1;
          if (ret_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_queue: got empty expected an instruction");
          end else begin
            r = ret_q.pop_front();
            chk("ard_mem_wb", 32'(ARD_MEM_WB), 32'(r.rd));
            chk("regwrite_mem_wb", 32'(REGWRITE_MEM_WB), 32'(r.rw));
            chk("wb_data_mem_wb", WB_DATA_MEM_WB, r.wb);
          end
        end else begin
          chk("regwrite_mem_wb_bubble", 32'(REGWRITE_MEM_WB), 32'd0);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic mtr,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic stall, input logic flush);
    exp_t e;
    ret_t r;
    EX_VALID = v; EX_RD = rd; EX_REGWRITE = rw; EX_MEMREAD = mr;
    EX_MEMWRITE = mw; EX_MEMTOREG = mtr; EX_ALU_RESULT = alu; EX_RS2_DATA = rs2;
    MEM_STALL = stall; FLUSH_EX_MEM = flush;
    @(posedge CLK);
    e.wbv = !stall && m_v;
    if (!stall) begin
      if (flush) begin
        m_v = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
      end else begin
        m_v = v; m_rd = rd; m_rw = v && rw && (rd != 5'd0);
        m_mr = v && mr; m_mw = v && mw; m_alu = alu; m_rs2 = rs2;
        if (v) begin
          r.rd = rd;
          r.rw = rw && (rd != 5'd0);
          r.wb = mtr ? mem_model(alu) : alu;
          ret_q.push_back(r);
        end
      end
    end
    e.v = m_v; e.rd = m_rd; e.rw = m_rw; e.mr = m_mr; e.mw = m_mw;
    e.alu = m_alu; e.rs2 = m_rs2;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic bubble(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    m_v = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    m_rd = '0; m_alu = '0; m_rs2 = '0;
    @(negedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    RST_N = 1'b1; MEM_STALL = 1'b0; FLUSH_EX_MEM = 1'b0; EX_VALID = 1'b0;
    EX_ALU_RESULT = '0; EX_RS2_DATA = '0; EX_RD = '0; EX_REGWRITE = 1'b0;
    EX_MEMREAD = 1'b0; EX_MEMWRITE = 1'b0; EX_MEMTOREG = 1'b0;
    #2;
    do_reset();

    // Reset then stream, then x0 suppression.
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h1111_1111, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h2222_2222, 1'b0, 1'b0);
    bubble(3);

    // Load to rd=5 held across a two-cycle memory wait.
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0066, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0066, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0066, 32'h0, 1'b0, 1'b0);
    bubble(2);

    // Flush a store to rd=7 behind a real instruction, then stall plus flush.
    drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 32'h7, 1'b0, 1'b1);
    drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00AA, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00BB, 32'hB, 1'b1, 1'b1);
    drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00BB, 32'hB, 1'b0, 1'b0);
    bubble(2);

    // Counter wrap: 18 back-to-back retirements on a 4-bit counter.
    for (int unsigned i = 0; i < 18; i++)
      drive(1'b1, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 4), 32'(i), 1'b0, 1'b0);
    bubble(3);

    // Async reset between edges while a stall is in force.
    drive(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b0);
    #2;
    do_reset();
    drive(1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h3, 1'b0, 1'b0);
    bubble(3);

    for (int unsigned i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      if (i == 200) begin
        #2;
        do_reset();
      end
    end
    bubble(4);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
